hilo_unit: RTL and testbench
============================

// Module: hilo_unit
// PURPOSE
//  HI/LO register unit between execute stage and iterative multiplier/divider.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from execute and drives the
//  multiplier start/operand interface. Also drives a divider with the same
//  handshake shape. Owns HI/LO and stalls the pipeline while an operation is in flight.
// PARAMETERS
//  WIDTH  32  data width; equals CPU_REG_WIDTH
// PORTS
//  clk           in   1        clock
//  rst           in   1        reset, asynchronous, active-high
//  op_valid      in   1        operation request from execute
//  op            in   3        0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MFHI,7 MFLO
//  rs            in   WIDTH    operand A / MTHI,MTLO data
//  rt            in   WIDTH    operand B
//  busy          out  1        operation in flight; execute must hold op_valid/op/rs/rt
//  result        out  WIDTH    MFHI/MFLO data
//  result_valid  out  1        one-cycle pulse, result valid
//  mul_start     out  1        multiplier start pulse
//  mul_signd     out  1        signed multiply
//  mul_a, mul_b  out  WIDTH    multiplicand/multiplier; held stable until mul_ready
//  mul_ready     in   1        multiplier idle (low during start cycle)
//  mul_product   in   2*WIDTH  multiplier result
//  div_start     out  1        divider start pulse
//  div_signd     out  1        signed divide
//  div_a, div_b  out  WIDTH    dividend/divisor; held stable until div_ready
//  div_ready     in   1        divider idle (low during start cycle)
//  div_quot      in   WIDTH    quotient
//  div_rem       in   WIDTH    remainder
// BEHAVIOUR
//  Reset: state IDLE; hi, lo, result, mul_a/b, div_a/b all 0.
//   busy, result_valid, mul_start, div_start, mul_signd and div_signd are 0.
//   The multiplier and divider get the same reset (inverted at top level), so rst mid-op aborts all.
//  Accept: an op is taken in a cycle with op_valid=1 && busy=0; op_valid while busy=1 is ignored.
//  FSM states: IDLE, MUL_START, MUL_WAIT, DIV_START, DIV_WAIT. busy=1 iff state!=IDLE (registered).
//  MULT/MULTU accept: latch mul_a<=rs, mul_b<=rt, mul_signd<=(op==MULT); go to MUL_START.
//  MUL_START: mul_start=1 for exactly this cycle; go to MUL_WAIT.
//  MUL_WAIT: on first cycle with mul_ready=1: hi<=mul_product[2W-1:W], lo<=mul_product[W-1:0], go IDLE.
//  DIV/DIVU accept, rt!=0: latch div_a/div_b/div_signd; go DIV_START.
//   DIV_START: div_start=1 for one cycle, then DIV_WAIT.
//   DIV_WAIT: on div_ready=1: hi<=div_rem, lo<=div_quot; go IDLE.
//  DIV/DIVU accept, rt==0: divider not started; hi<=rs, lo<={WIDTH{1}} at the accept edge; stay IDLE.
//  MTHI/MTLO: hi<=rs or lo<=rs at the accept edge; stay IDLE; busy stays 0.
//  MFHI/MFLO: result<=hi or lo at the accept edge; result_valid=1 the next cycle only.
//   The value read is the one before any same-edge write.
//  mul_a/mul_b/div_a/div_b change only at the accept edge. Sign correction downstream reads them
//   combinationally, so they must not change before the corresponding ready.
//  Latency, W=32, nonzero multiply operands, accept in cycle t:
//   mul_start in t+1; busy high t+1..t+34; hi/lo updated at end of t+34; busy=0 in t+35.
//  Multiply with a zero operand: mul_ready=1 in t+2, so busy is high t+1..t+2 and hi=lo=0.
//  Reset asserted in any state: immediate return to reset values; a pending write is lost.
// TESTING
//  MULT rs=0xFFFFFFFD, rt=7 -> busy 34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; mul_start exactly 1 cycle.
//  MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; mul_signd=0 throughout.
//  MULT rs=0, rt=5 -> busy exactly 2 cycles; hi=lo=0.
//  DIV rs=0x12345678, rt=0 -> div_start never asserted; busy stays 0; hi=0x12345678, lo=0xFFFFFFFF.
//  MTHI 0xA5A5A5A5, then MFHI -> result=0xA5A5A5A5 with one-cycle result_valid.
//   MFLO while busy=1 -> no result_valid until busy drops.
//  Reset asserted at t+10 of a MULT -> busy=0, hi=lo=0, mul_start=0 same cycle.
//   A new MULT afterward completes correctly.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO register unit: executes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO,
// sequences the iterative multiplier/divider and stalls execute while one is running.
module hilo_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    output logic               busy,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    output logic               mul_start,
    output logic               mul_signd,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_ready,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               div_start,
    output logic               div_signd,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_b,
    input  logic               div_ready,
    input  logic [WIDTH-1:0]   div_quot,
    input  logic [WIDTH-1:0]   div_rem
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_START = 3'd1,
        MUL_WAIT  = 3'd2,
        DIV_START = 3'd3,
        DIV_WAIT  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hi, hi_nxt;
    logic [WIDTH-1:0] lo, lo_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             result_valid_nxt;
    logic             mul_signd_nxt, div_signd_nxt;
    logic [WIDTH-1:0] mul_a_nxt, mul_b_nxt, div_a_nxt, div_b_nxt;

    // Next-state, HI/LO update and operand capture
    always_comb begin
        state_nxt        = state;
        hi_nxt           = hi;
        lo_nxt           = lo;
        result_nxt       = result;
        result_valid_nxt = 1'b0;
        mul_signd_nxt    = mul_signd;
        mul_a_nxt        = mul_a;
        mul_b_nxt        = mul_b;
        div_signd_nxt    = div_signd;
        div_a_nxt        = div_a;
        div_b_nxt        = div_b;

        unique case (state)
            IDLE: begin
                if (op_valid) begin
                    unique case (op)
                        OP_MULT, OP_MULTU: begin
                            mul_a_nxt     = rs;
                            mul_b_nxt     = rt;
                            mul_signd_nxt = (op == OP_MULT);
                            state_nxt     = MUL_START;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero never reaches the divider
                            if (rt != '0) begin
                                div_a_nxt     = rs;
                                div_b_nxt     = rt;
                                div_signd_nxt = (op == OP_DIV);
                                state_nxt     = DIV_START;
                            end else begin
                                hi_nxt = rs;
                                lo_nxt = '1;
                            end
                        end
                        OP_MTHI: hi_nxt = rs;
                        OP_MTLO: lo_nxt = rs;
                        OP_MFHI: begin
                            result_nxt       = hi;
                            result_valid_nxt = 1'b1;
                        end
                        OP_MFLO: begin
                            result_nxt       = lo;
                            result_valid_nxt = 1'b1;
                        end
                    endcase
                end
            end
            MUL_START: state_nxt = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_ready) begin
                    hi_nxt    = mul_product[2*WIDTH-1:WIDTH];
                    lo_nxt    = mul_product[WIDTH-1:0];
                    state_nxt = IDLE;
                end
            end
            DIV_START: state_nxt = DIV_WAIT;
            DIV_WAIT: begin
                if (div_ready) begin
                    hi_nxt    = div_rem;
                    lo_nxt    = div_quot;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hi           <= '0;
            lo           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            mul_start    <= 1'b0;
            mul_signd    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            div_start    <= 1'b0;
            div_signd    <= 1'b0;
            div_a        <= '0;
            div_b        <= '0;
        end else begin
            state        <= state_nxt;
            hi           <= hi_nxt;
            lo           <= lo_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            busy         <= (state_nxt != IDLE);
            mul_start    <= (state_nxt == MUL_START);
            mul_signd    <= mul_signd_nxt;
            mul_a        <= mul_a_nxt;
            mul_b        <= mul_b_nxt;
            div_start    <= (state_nxt == DIV_START);
            div_signd    <= div_signd_nxt;
            div_a        <= div_a_nxt;
            div_b        <= div_b_nxt;
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: transaction-level HI/LO model, mock multiplier/divider,
// per-cycle output comparison plus directed literal expectations.
module tb_hilo_unit;

    localparam int unsigned W = 32;
    localparam int unsigned DIV_LAT = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  rs = '0;
    logic [W-1:0]  rt = '0;
    logic          busy, result_valid;
    logic [W-1:0]  result;
    logic          mul_start, mul_signd, mul_ready;
    logic [W-1:0]  mul_a, mul_b;
    logic [2*W-1:0] mul_product;
    logic          div_start, div_signd, div_ready;
    logic [W-1:0]  div_a, div_b, div_quot, div_rem;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hilo_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
        .busy(busy), .result(result), .result_valid(result_valid),
        .mul_start(mul_start), .mul_signd(mul_signd), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_product(mul_product),
        .div_start(div_start), .div_signd(div_signd), .div_a(div_a), .div_b(div_b),
        .div_ready(div_ready), .div_quot(div_quot), .div_rem(div_rem)
    );

    function automatic logic [63:0] mulf(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'h0, a});
            y = longint'({32'h0, b});
        end
        return 64'(x * y);
    endfunction

    // returns {remainder, quotient}
    function automatic logic [63:0] divf(input logic [31:0] a, input logic [31:0] b, input logic s);
        int sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    // Mock multiplier: 32-cycle run, immediate finish for a zero operand
    int unsigned mcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt <= 0;
            mul_product <= '0;
        end else if (mul_start) begin
            mcnt <= (mul_a == 0 || mul_b == 0) ? 0 : 32;
            mul_product <= mulf(mul_a, mul_b, mul_signd);
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end
    assign mul_ready = (mcnt == 0) && !mul_start;

    // Mock divider
    int unsigned dcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= 0;
            {div_rem, div_quot} <= '0;
        end else if (div_start) begin
            dcnt <= DIV_LAT;
            {div_rem, div_quot} <= divf(div_a, div_b, div_signd);
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
        end
    end
    assign div_ready = (dcnt == 0) && !div_start;

    // Transaction-level model of expected outputs
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          busy_left;
    logic        e_busy, e_mstart, e_dstart, e_rv, e_msignd, e_dsignd;
    logic [31:0] e_result, e_ma, e_mb, e_da, e_db;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; busy_left = 0;
                e_busy = 0; e_mstart = 0; e_dstart = 0; e_rv = 0; e_msignd = 0; e_dsignd = 0;
                e_result = 0; e_ma = 0; e_mb = 0; e_da = 0; e_db = 0;
            end else begin
                e_mstart = 0;
                e_dstart = 0;
                e_rv = 0;
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) begin
                        m_hi = p_hi;
                        m_lo = p_lo;
                    end
                end else if (op_valid) begin
                    case (op)
                        3'd0, 3'd1: begin
                            e_ma = rs; e_mb = rt; e_msignd = (op == 3'd0);
                            {p_hi, p_lo} = mulf(rs, rt, e_msignd);
                            busy_left = (rs == 0 || rt == 0) ? 2 : 34;
                            e_mstart = 1;
                        end
                        3'd2, 3'd3: begin
                            if (rt == 0) begin
                                m_hi = rs;
                                m_lo = 32'hFFFF_FFFF;
                            end else begin
                                e_da = rs; e_db = rt; e_dsignd = (op == 3'd2);
                                {p_hi, p_lo} = divf(rs, rt, e_dsignd);
                                busy_left = DIV_LAT + 2;
                                e_dstart = 1;
                            end
                        end
                        3'd4: m_hi = rs;
                        3'd5: m_lo = rs;
                        3'd6: begin e_result = m_hi; e_rv = 1; end
                        default: begin e_result = m_lo; e_rv = 1; end
                    endcase
                end
                e_busy = (busy_left > 0);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy",         64'(busy),         64'(e_busy));
        chk("mul_start",    64'(mul_start),    64'(e_mstart));
        chk("div_start",    64'(div_start),    64'(e_dstart));
        chk("result_valid", 64'(result_valid), 64'(e_rv));
        chk("result",       64'(result),       64'(e_result));
        chk("mul_signd",    64'(mul_signd),    64'(e_msignd));
        chk("div_signd",    64'(div_signd),    64'(e_dsignd));
        chk("mul_a",        64'(mul_a),        64'(e_ma));
        chk("mul_b",        64'(mul_b),        64'(e_mb));
        chk("div_a",        64'(div_a),        64'(e_da));
        chk("div_b",        64'(div_b),        64'(e_db));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present an op and hold it until the cycle it is accepted; returns at accept edge + 1
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic bz;
        op = o; rs = a; rt = b; op_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            bz = busy;
            @(posedge clk);
            #1;
            if (!bz) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'(1), 64'(0));
                break;
            end
        end
        op_valid = 1'b0;
    endtask

    task automatic measure(input string name, input int exp_busy);
        int nb, ns;
        nb = 0; ns = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (mul_start || div_start) ns++;
            if (nb > 200) break;
        end
        chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
        chk({name, "_start_cycles"}, 64'(ns), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [2:0] o, input logic [31:0] exp);
        int n;
        issue(o, 32'h0, 32'h0);
        n = 0;
        forever begin
            @(negedge clk);
            if (result_valid || n > 200) break;
            n++;
        end
        chk({name, "_rv"}, 64'(result_valid), 64'(1));
        chk(name, 64'(result), 64'(exp));
        @(negedge clk);
        chk({name, "_rv_pulse"}, 64'(result_valid), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(2);
        chk("rst_busy",   64'(busy),   64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_mul_a",  64'(mul_a),  64'(0));
        rst = 1'b0;
        cyc(1);

        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        measure("mult", 34);
        rd("mult_hi", 3'd6, 32'hFFFF_FFFF);
        rd("mult_lo", 3'd7, 32'hFFFF_FFEB);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_signd", 64'(mul_signd), 64'(0));
        measure("multu", 34);
        rd("multu_hi", 3'd6, 32'hFFFF_FFFE);
        rd("multu_lo", 3'd7, 32'h0000_0001);

        issue(3'd0, 32'h0, 32'd5);
        measure("mult_zero", 2);
        rd("mult_zero_hi", 3'd6, 32'h0);
        rd("mult_zero_lo", 3'd7, 32'h0);

        issue(3'd2, 32'h1234_5678, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("div0_busy", 64'(busy), 64'(0));
            chk("div0_start", 64'(div_start), 64'(0));
        end
        cyc(1);
        rd("div0_hi", 3'd6, 32'h1234_5678);
        rd("div0_lo", 3'd7, 32'hFFFF_FFFF);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        measure("div", DIV_LAT + 2);
        rd("div_hi", 3'd6, 32'hFFFF_FFFF);
        rd("div_lo", 3'd7, 32'hFFFF_FFFD);

        issue(3'd3, 32'd100, 32'd7);
        measure("divu", DIV_LAT + 2);
        rd("divu_hi", 3'd6, 32'd2);
        rd("divu_lo", 3'd7, 32'd14);

        issue(3'd4, 32'hA5A5_A5A5, 32'h0);
        rd("mthi", 3'd6, 32'hA5A5_A5A5);
        issue(3'd5, 32'h0BAD_F00D, 32'h0);
        rd("mtlo", 3'd7, 32'h0BAD_F00D);

        // MFLO presented while a multiply is in flight
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        rd("mflo_busy", 3'd7, 32'hFFFF_FFEB);

        // Reset in the middle of a multiply
        issue(3'd4, 32'h1111_1111, 32'h0);
        issue(3'd0, 32'd3, 32'd5);
        cyc(9);
        rst = 1'b1;
        #1;
        chk("midrst_busy",      64'(busy),      64'(0));
        chk("midrst_mul_start", 64'(mul_start), 64'(0));
        chk("midrst_mul_a",     64'(mul_a),     64'(0));
        cyc(1);
        rst = 1'b0;
        cyc(1);
        rd("midrst_hi", 3'd6, 32'h0);
        rd("midrst_lo", 3'd7, 32'h0);
        issue(3'd0, 32'd3, 32'd5);
        measure("post_rst_mult", 34);
        rd("post_rst_lo", 3'd7, 32'd15);
        rd("post_rst_hi", 3'd6, 32'h0);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
